// File: rtl/cdc_mmio_bridge_pkg.sv
// Shared register indices, bit positions and payload types for the CDC MMIO bridge.
package cdc_mmio_bridge_pkg;

  // Word register indices on addr_i
  typedef enum logic [1:0] {
    CDC_REG_DATA   = 2'd0,
    CDC_REG_STATUS = 2'd1,
    CDC_REG_CTRL   = 2'd2,
    CDC_REG_ERR    = 2'd3
  } cdc_reg_e;

  localparam int unsigned REG_W          = 32;
  localparam int unsigned CNT_W          = 8;

  // DATA register
  localparam int unsigned DATA_VALID_BIT = 31;

  // STATUS register
  localparam int unsigned STAT_RX_CNT_LSB = 0;
  localparam int unsigned STAT_TX_CNT_LSB = 8;
  localparam int unsigned STAT_RX_EMPTY   = 16;
  localparam int unsigned STAT_RX_FULL    = 17;
  localparam int unsigned STAT_TX_EMPTY   = 18;
  localparam int unsigned STAT_TX_FULL    = 19;

  // CTRL register
  localparam int unsigned CTRL_RX_THR_LSB = 0;
  localparam int unsigned CTRL_TX_THR_LSB = 8;
  localparam int unsigned CTRL_RX_IE      = 16;
  localparam int unsigned CTRL_TX_IE      = 17;
  localparam int unsigned CTRL_ERR_IE     = 18;
  localparam int unsigned CTRL_RX_FLUSH   = 19;
  localparam int unsigned CTRL_TX_FLUSH   = 20;
  localparam int unsigned CTRL_STORE_W    = 19;

  // ERR register
  localparam int unsigned ERR_TXOVF  = 0;
  localparam int unsigned ERR_RXUNF  = 1;
  localparam int unsigned ERR_RXDROP = 2;
  localparam int unsigned ERR_W      = 3;

  // Persistent CTRL fields, laid out to match CTRL[18:0]
  typedef struct packed {
    logic             err_ie;
    logic             tx_ie;
    logic             rx_ie;
    logic [CNT_W-1:0] tx_thresh;
    logic [CNT_W-1:0] rx_thresh;
  } cdc_ctrl_t;

  // Clamp a FIFO occupancy to the 8-bit STATUS field
  function automatic logic [CNT_W-1:0] sat8(input logic [31:0] c);
    return (c > 32'd255) ? 8'hFF : c[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cdc_mmio_bridge_fifo.sv
// Synchronous FIFO with flush; head symbol presented combinationally from storage.
// Ports: clk_i/rst_i, push/pop/flush controls, wdata in, rdata (head, 0 when empty),
//        count/full/empty status derived from the registered occupancy.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; flush overrides any same-cycle traffic
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only visible through rd_ptr when non-empty
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cdc_mmio_bridge.sv
// MMIO peripheral bridging the CPU data bus to the USB_CDC byte streams.
// Ports: clk_i/rst_i; bus sel_i/read_i/write_i/addr_i/wdata_i -> rdata_o/rvalid_o;
//        irq_o level interrupt; TX stream in_data_o/in_valid_o/in_ready_i;
//        RX stream out_data_i/out_valid_i/out_ready_o.
module cdc_mmio_bridge
  import cdc_mmio_bridge_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [1:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              irq_o,
  output logic [DATA_W-1:0] in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  input  logic [DATA_W-1:0] out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o
);

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  cdc_reg_e          reg_sel;
  logic              rd_req;
  logic              wr_req;

  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head;
  logic [RX_CW-1:0]  rx_count;
  logic [TX_CW-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_cnt8, tx_cnt8;

  cdc_ctrl_t         ctrl_q;
  logic              rx_flush_q, tx_flush_q;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_set_c, err_clr_c;
  logic [CNT_W-1:0]  stall_q;
  logic [31:0]       rd_data_c;
  logic              irq_c;
  logic              unused_wdata;

  assign reg_sel = cdc_reg_e'(addr_i);
  assign rd_req  = sel_i && read_i;
  // Read wins over a simultaneous write
  assign wr_req  = sel_i && write_i && !read_i;

  assign out_ready_o = !rx_full;
  assign in_valid_o  = !tx_empty;

  assign rx_push = out_valid_i && out_ready_o;
  assign rx_pop  = rd_req && (reg_sel == CDC_REG_DATA) && !rx_empty;
  assign tx_push = wr_req && (reg_sel == CDC_REG_DATA) && !tx_full;
  assign tx_pop  = in_valid_o && in_ready_i;

  assign rx_cnt8 = sat8(32'(rx_count));
  assign tx_cnt8 = sat8(32'(tx_count));

  assign unused_wdata = ^wdata_i[31:21];

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush_q),
    .wdata (out_data_i),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush_q),
    .wdata (wdata_i[DATA_W-1:0]),
    .rdata (in_data_o),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Read mux; flush bits always read back as 0
  always_comb begin
    rd_data_c = '0;
    case (reg_sel)
      CDC_REG_DATA:   rd_data_c = rx_empty ? 32'd0 : {1'b1, 15'b0, 16'(rx_head)};
      CDC_REG_STATUS: rd_data_c = {12'b0, tx_full, tx_empty, rx_full, rx_empty, tx_cnt8, rx_cnt8};
      CDC_REG_CTRL:   rd_data_c = {13'b0, ctrl_q};
      CDC_REG_ERR:    rd_data_c = {29'b0, err_q};
    endcase
  end

  // Error event detection and write-1-to-clear mask
  always_comb begin
    err_set_c             = '0;
    err_set_c[ERR_TXOVF]  = wr_req && (reg_sel == CDC_REG_DATA) && tx_full;
    err_set_c[ERR_RXUNF]  = rd_req && (reg_sel == CDC_REG_DATA) && rx_empty;
    err_set_c[ERR_RXDROP] = out_valid_i && rx_full && (stall_q == 8'hFF);
    err_clr_c             = (wr_req && (reg_sel == CDC_REG_ERR)) ? wdata_i[ERR_W-1:0] : '0;
  end

  always_comb begin
    irq_c = (ctrl_q.rx_ie && (rx_cnt8 >= ctrl_q.rx_thresh) && (ctrl_q.rx_thresh != '0)) ||
            (ctrl_q.tx_ie && (tx_cnt8 <= ctrl_q.tx_thresh)) ||
            (ctrl_q.err_ie && (|err_q));
  end

  // Bus response, control/error registers, RX stall counter and interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o    <= '0;
      rvalid_o   <= 1'b0;
      ctrl_q     <= '0;
      rx_flush_q <= 1'b0;
      tx_flush_q <= 1'b0;
      err_q      <= '0;
      stall_q    <= '0;
      irq_o      <= 1'b0;
    end else begin
      rvalid_o <= rd_req;
      if (rd_req) rdata_o <= rd_data_c;

      if (wr_req && (reg_sel == CDC_REG_CTRL)) begin
        ctrl_q     <= cdc_ctrl_t'(wdata_i[CTRL_STORE_W-1:0]);
        rx_flush_q <= wdata_i[CTRL_RX_FLUSH];
        tx_flush_q <= wdata_i[CTRL_TX_FLUSH];
      end else begin
        rx_flush_q <= 1'b0;
        tx_flush_q <= 1'b0;
      end

      // Set has priority over a same-cycle clear
      err_q <= (err_q & ~err_clr_c) | err_set_c;

      // Consecutive cycles of an offered RX symbol refused because the FIFO is full
      if (out_valid_i && rx_full) begin
        if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
      end else begin
        stall_q <= '0;
      end

      irq_o <= irq_c;
    end
  end

endmodule

// File: tb/tb_cdc_mmio_bridge.sv
// Self-checking bench for cdc_mmio_bridge: bus reads are scoreboarded through a queue
// of expected rdata values that is drained whenever rvalid_o is seen.
module tb_cdc_mmio_bridge;

  localparam int unsigned RXD = 4;
  localparam int unsigned TXD = 16;
  localparam int unsigned DW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sel_i, read_i, write_i;
  logic [1:0]    addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          rvalid_o;
  logic          irq_o;
  logic [DW-1:0] in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic [DW-1:0] out_data_i;
  logic          out_valid_i;
  logic          out_ready_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   rq [$];
  logic [DW-1:0] rx_m [$];
  logic [DW-1:0] tx_m [$];
  logic [2:0]    err_m;
  int            acc;

  cdc_mmio_bridge #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sel_i       (sel_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .irq_o       (irq_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Read response scoreboard
  always @(negedge clk_i) begin
    if (!rst_i && rvalid_o) begin
      if (rq.size() == 0) chk("rvalid_spurious", 32'(rvalid_o), 32'd0);
      else                chk("rdata", rdata_o, rq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] status_exp();
    int rc = rx_m.size();
    int tc = tx_m.size();
    return {12'b0, (tc == TXD), (tc == 0), (rc == RXD), (rc == 0), 8'(tc), 8'(rc)};
  endfunction

  // All bus/stream tasks start and end at a falling edge
  task automatic bus_read(input logic [1:0] a, input logic [31:0] e);
    sel_i = 1'b1; read_i = 1'b1; addr_i = a;
    rq.push_back(e);
    @(negedge clk_i);
    sel_i = 1'b0; read_i = 1'b0;
    chk("rvalid_latency", 32'(rvalid_o), 32'd1);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1'b1; write_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    sel_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic rd_data();
    logic [31:0] e;
    if (rx_m.size() > 0) e = {1'b1, 15'b0, 8'b0, rx_m.pop_front()};
    else begin
      e = 32'd0;
      err_m[1] = 1'b1;
    end
    bus_read(2'd0, e);
  endtask

  task automatic wr_tx(input logic [DW-1:0] d);
    if (tx_m.size() == TXD) err_m[0] = 1'b1;
    else                    tx_m.push_back(d);
    bus_write(2'd0, 32'(d));
  endtask

  task automatic clr_err();
    bus_write(2'd3, 32'h7);
    err_m = 3'b0;
  endtask

  task automatic rx_push(input logic [DW-1:0] d);
    int n = 0;
    out_data_i = d; out_valid_i = 1'b1;
    while (!out_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) chk("rx_push_timeout", 32'(n), 32'd0);
    rx_m.push_back(d);
    @(negedge clk_i);
    out_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    addr_i = 2'd0; wdata_i = 32'd0; in_ready_i = 1'b0;
    out_data_i = '0; out_valid_i = 1'b0; err_m = 3'b0;
    #1;
    chk("rst_rdata",     rdata_o,                32'd0);
    chk("rst_rvalid",    32'(rvalid_o),          32'd0);
    chk("rst_irq",       32'(irq_o),             32'd0);
    chk("rst_in_valid",  32'(in_valid_o),        32'd0);
    chk("rst_out_ready", 32'(out_ready_o),       32'd1);
    chk("rst_in_data",   32'(in_data_o),         32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // RX bytes read back in order, then underflow
    rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
    repeat (4) rd_data();
    bus_read(2'd3, {29'b0, err_m});
    clr_err();
    bus_read(2'd3, 32'd0);

    // TX overflow, then drain one per cycle
    for (int i = 0; i < 17; i++) wr_tx(8'h10 + 8'(i));
    bus_read(2'd1, status_exp());
    bus_read(2'd3, {29'b0, err_m});
    clr_err();
    in_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_valid", 32'(in_valid_o), 32'd1);
      chk("tx_data",  32'(in_data_o),  32'(tx_m.pop_front()));
      @(negedge clk_i);
    end
    chk("tx_drained", 32'(in_valid_o), 32'd0);
    in_ready_i = 1'b0;

    // RX backpressure at full, released by one DATA read
    out_data_i = 8'h60; out_valid_i = 1'b1; acc = 0;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      if (out_ready_o) begin
        rx_m.push_back(out_data_i);
        acc++;
        @(negedge clk_i);
        out_data_i = out_data_i + 8'd1;
      end else begin
        @(negedge clk_i);
      end
    end
    chk("rx_full_ready", 32'(out_ready_o), 32'd0);
    rd_data();
    chk("rx_ready_after_pop", 32'(out_ready_o), 32'd1);
    rx_m.push_back(out_data_i);
    @(negedge clk_i);
    out_valid_i = 1'b0;
    bus_read(2'd1, status_exp());

    // RX drop: 255 stalled cycles is tolerated, the 256th flags (and beats a W1C)
    out_data_i = 8'h99; out_valid_i = 1'b1;
    repeat (255) @(negedge clk_i);
    out_valid_i = 1'b0;
    @(negedge clk_i);
    bus_read(2'd3, 32'd0);
    out_valid_i = 1'b1;
    repeat (255) @(negedge clk_i);
    bus_write(2'd3, 32'h4);
    out_valid_i = 1'b0;
    err_m[2] = 1'b1;
    bus_read(2'd3, {29'b0, err_m});
    clr_err();
    bus_read(2'd3, 32'd0);
    repeat (4) rd_data();
    clr_err();

    // RX threshold interrupt
    bus_write(2'd2, 32'h0001_0002);
    rx_push(8'h71);
    @(negedge clk_i);
    chk("irq_below_thresh", 32'(irq_o), 32'd0);
    rx_push(8'h72);
    @(negedge clk_i);
    chk("irq_at_thresh", 32'(irq_o), 32'd1);
    rd_data();
    @(negedge clk_i);
    chk("irq_after_read", 32'(irq_o), 32'd0);
    rd_data();
    bus_write(2'd2, 32'd0);

    // TX flush
    for (int i = 0; i < 5; i++) wr_tx(8'h80 + 8'(i));
    chk("tx_valid_before_flush", 32'(in_valid_o), 32'd1);
    bus_write(2'd2, 32'h0010_0305);
    tx_m.delete();
    @(negedge clk_i);
    chk("tx_valid_after_flush", 32'(in_valid_o), 32'd0);
    bus_read(2'd1, status_exp());
    bus_read(2'd2, 32'h0000_0305);

    // Asynchronous reset in the middle of traffic with a read response in flight
    rx_push(8'h91); rx_push(8'h92);
    wr_tx(8'hA1); wr_tx(8'hA2); wr_tx(8'hA3);
    out_data_i = 8'h93; out_valid_i = 1'b1;
    sel_i = 1'b1; read_i = 1'b1; addr_i = 2'd1;
    @(posedge clk_i);
    #2;
    sel_i = 1'b0; read_i = 1'b0; out_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("arst_rdata",     rdata_o,          32'd0);
    chk("arst_rvalid",    32'(rvalid_o),    32'd0);
    chk("arst_irq",       32'(irq_o),       32'd0);
    chk("arst_in_valid",  32'(in_valid_o),  32'd0);
    chk("arst_out_ready", 32'(out_ready_o), 32'd1);
    chk("arst_in_data",   32'(in_data_o),   32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    rx_m.delete(); tx_m.delete(); rq.delete(); err_m = 3'b0;
    @(negedge clk_i);
    bus_read(2'd1, status_exp());
    rd_data();
    bus_read(2'd3, {29'b0, err_m});
    bus_read(2'd2, 32'd0);

    @(negedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
